// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: EX-stage operand forwarding plus decode-stage hazard
// detection. Load-use hazards stall for LOAD_STALL cycles. With forwarding
// disabled, every RAW hazard against EX or MEM stalls until it clears.
// A saturating counter records the number of stalled cycles.
//
// Control contract: stall holds PC and IF_ID, and bubble zeroes the ID_EX
// control fields. Both are level signals that the pipeline honours in the
// same cycle, and both are always equal. No valid/ready handshake exists.
// The pipeline must accept the request unconditionally.
module hazard_fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fwd_enable,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
    input  logic [REG_ADDR_W-1:0] ID_EX_rs1,
    input  logic [REG_ADDR_W-1:0] ID_EX_rs2,
    input  logic [REG_ADDR_W-1:0] ID_EX_rd,
    input  logic                  ID_EX_RegWrite,
    input  logic                  ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
    input  logic                  EX_MEM_RegWrite,
    input  logic [REG_ADDR_W-1:0] MEM_WB_rd,
    input  logic                  MEM_WB_RegWrite,
    output logic [1:0]            Forward_A,
    output logic [1:0]            Forward_B,
    output logic                  stall,
    output logic                  bubble,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic                  dbg_state_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LSTALL = 1'b1
    } state_e;

    // Reload value for the remaining cycles after the first stall cycle.
    localparam logic [3:0] LS_RELOAD = 4'(LOAD_STALL - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             stall_c;
    logic             luh;
    logic             rawh;

    // A source register matches a destination only when both are the same
    // nonzero register. Register 0 is hardwired to zero.
    function automatic logic src_match(input logic [REG_ADDR_W-1:0] src,
                                       input logic [REG_ADDR_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    // Operand forwarding. EX/MEM holds the younger result, so it takes
    // priority over MEM/WB. Forwarding is forced to 00 when disabled or held in reset.
    always_comb begin
        Forward_A = 2'b00;
        Forward_B = 2'b00;
        if (!reset && fwd_enable) begin
            if (EX_MEM_RegWrite && src_match(ID_EX_rs1, EX_MEM_rd)) begin
                Forward_A = 2'b10;
            end else if (MEM_WB_RegWrite && src_match(ID_EX_rs1, MEM_WB_rd)) begin
                Forward_A = 2'b01;
            end
            if (EX_MEM_RegWrite && src_match(ID_EX_rs2, EX_MEM_rd)) begin
                Forward_B = 2'b10;
            end else if (MEM_WB_RegWrite && src_match(ID_EX_rs2, MEM_WB_rd)) begin
                Forward_B = 2'b01;
            end
        end
    end

    // Decode-stage hazard terms. MEM/WB is excluded because the register file
    // writes before it reads.
    always_comb begin
        luh  = ID_EX_MemRead &&
               (src_match(IF_ID_rs1, ID_EX_rd) || src_match(IF_ID_rs2, ID_EX_rd));
        rawh = (ID_EX_RegWrite &&
                (src_match(IF_ID_rs1, ID_EX_rd) || src_match(IF_ID_rs2, ID_EX_rd))) ||
               (EX_MEM_RegWrite &&
                (src_match(IF_ID_rs1, EX_MEM_rd) || src_match(IF_ID_rs2, EX_MEM_rd)));
    end

    // Next-state and stall decode. LSTALL ignores all inputs until the count expires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fwd_enable) begin
                    if (luh) begin
                        stall_c = 1'b1;
                        if (LOAD_STALL > 1) begin
                            cnt_d   = LS_RELOAD;
                            state_d = LSTALL;
                        end
                    end
                end else if (luh || rawh) begin
                    stall_c = 1'b1;
                end
            end
            LSTALL: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and stall-length counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating count of stalled cycles. The counter holds at all-ones
    // instead of wrapping.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall        = stall_c && !reset;
    assign bubble       = stall;
    assign stall_cycles = stall_cycles_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Parametrised successor to the pipeline forwarding unit. It combines EX-stage operand forwarding (Forward_A/Forward_B) with decode-stage load-use hazard detection. The load-use stall length is configurable, and a no-forwarding mode stalls on every RAW hazard instead of forwarding. The block sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and drives the PC/IF_ID hold and ID_EX bubble controls, plus a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, width of register specifiers; register 0 is hardwired zero and never hazards.
LOAD_STALL, 1, bubble cycles inserted per load-use hazard; legal range 1..15.
CNT_W, 16, width of the stall_cycles performance counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
fwd_enable  in  1  1 = forwarding mode; 0 = stall-only mode
IF_ID_rs1  in  REG_ADDR_W  decode-stage source 1
IF_ID_rs2  in  REG_ADDR_W  decode-stage source 2
ID_EX_rs1  in  REG_ADDR_W  EX-stage source 1
ID_EX_rs2  in  REG_ADDR_W  EX-stage source 2
ID_EX_rd  in  REG_ADDR_W  EX-stage destination
ID_EX_RegWrite  in  1  EX-stage instruction writes rd
ID_EX_MemRead  in  1  EX-stage instruction is a load
EX_MEM_rd  in  REG_ADDR_W  MEM-stage destination
EX_MEM_RegWrite  in  1  MEM-stage instruction writes rd
MEM_WB_rd  in  REG_ADDR_W  WB-stage destination
MEM_WB_RegWrite  in  1  WB-stage instruction writes rd
Forward_A  out  2  ALU operand A mux select: 00 regfile, 10 EX/MEM, 01 MEM/WB
Forward_B  out  2  ALU operand B mux select, same encoding
stall  out  1  hold PC and IF_ID
bubble  out  1  zero the ID_EX control fields
stall_cycles  out  CNT_W  count of cycles with stall=1

Behaviour:
- Reset values: stall=0, bubble=0, stall_cycles=0, state=IDLE, counter=0. Forward_A/B=00 while reset is high.
- Forwarding is combinational, zero latency. Forward_A:
  - 10 if EX_MEM_RegWrite, EX_MEM_rd!=0 and EX_MEM_rd==ID_EX_rs1.
  - Otherwise 01 if MEM_WB_RegWrite, MEM_WB_rd!=0 and MEM_WB_rd==ID_EX_rs1.
  - Otherwise 00.
  - Forward_B follows the same rules on ID_EX_rs2.
  - When fwd_enable=0, both are forced to 00.
- Hazard terms. A decode source "matches" X when it is nonzero and equals X.
  - luh (load-use hazard): ID_EX_MemRead and (IF_ID_rs1 or IF_ID_rs2 matches ID_EX_rd).
  - rawh (RAW hazard, used only when fwd_enable=0): either decode source matches ID_EX_rd with ID_EX_RegWrite, or matches EX_MEM_rd with EX_MEM_RegWrite.
  - MEM_WB never causes a stall, because the regfile writes before it reads.
- State machine with a 4-bit counter cnt:
  - IDLE:
    - If fwd_enable=1 and luh: stall=bubble=1 this cycle. If LOAD_STALL>1, load cnt=LOAD_STALL-1 and go to LSTALL.
    - If fwd_enable=0 and (luh or rawh): stall=bubble=1 combinationally, stay in IDLE. The stall repeats each cycle until the hazard clears.
    - Otherwise stall=bubble=0.
  - LSTALL: stall=bubble=1 regardless of inputs. cnt decrements each cycle; when cnt==1 the next state is IDLE. Total stalled cycles per load-use hazard = LOAD_STALL exactly.
- In LSTALL, fwd_enable changes and new hazards are ignored until the return to IDLE. Hazards are then re-evaluated in IDLE.
- stall_cycles increments by 1 on every clock edge where stall=1 and reset=0. It saturates at all-ones and does not wrap.
- Reset mid-LSTALL: on the next edge, state=IDLE, cnt=0, counter cleared. stall/bubble deassert from that edge.
- Simultaneous EX_MEM and MEM_WB match on the same register: EX_MEM wins (10).
- rd=0 or rs=0 never produces forwarding or a stall.

Test Plan:
- fwd_enable=1, EX_MEM_rd=5 with RegWrite, MEM_WB_rd=5 with RegWrite, ID_EX_rs1=5, ID_EX_rs2=0 -> Forward_A=10, Forward_B=00, stall=0.
- fwd_enable=1, LOAD_STALL=1, ID_EX_MemRead=1, ID_EX_rd=7, IF_ID_rs2=7; next cycle ID_EX bubbled (MemRead=0) -> stall=bubble=1 for exactly 1 cycle, then 0; stall_cycles=1.
- LOAD_STALL=3, same load-use -> stall=1 for exactly 3 consecutive cycles, even though the hazard inputs clear after cycle 1; stall_cycles=3.
- fwd_enable=0, EX_MEM_rd=4 with RegWrite, IF_ID_rs1=4 -> stall=bubble=1 and Forward_A=00 while it holds. Change EX_MEM_rd to 0 -> stall=0 the same cycle.
- LOAD_STALL=4: assert reset during the 2nd stall cycle -> after the edge stall=0, stall_cycles=0, state IDLE. With no hazard present, no further stalls occur.
- CNT_W=4: hold a fwd_enable=0 hazard for 20 cycles -> stall_cycles saturates at 15 and stays at 15.
